led_row_sched: RTL and testbench

Row scheduler for the backlight-zone path of the local-dimming pipeline. It sequences reads of zone luminance bytes from the zone FIFO and steers each byte to a slot of the row packer using a write strobe and a slot index. When a row is complete it presents that row to the LED driver transmitter with a valid/ready handshake, and it tracks the row index across a frame. A frame-sync input realigns the scheduler and flags frames that arrive misaligned.

---
 rtl/led_row_sched_if.sv | 29 ++
 rtl/led_row_sched.sv | 128 ++++++++++++
 tb/tb_led_row_sched.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/led_row_sched_if.sv
// Scheduler-side bundle: zone FIFO read port, row packer slot writes,
// and the row valid/ready handshake toward the LED driver transmitter.
interface led_row_sched_if;
  logic       enable;
  logic       frame_sync;
  logic       fifo_empty;
  logic       fifo_rd_en;
  logic [7:0] fifo_dout;
  logic       byte_we;
  logic [5:0] byte_idx;
  logic [7:0] byte_data;
  logic       row_valid;
  logic       row_ready;
  logic [5:0] row_idx;
  logic       frame_done;
  logic       sync_err;

  modport master (
    input  enable, frame_sync, fifo_empty, fifo_dout, row_ready,
    output fifo_rd_en, byte_we, byte_idx, byte_data, row_valid, row_idx,
           frame_done, sync_err
  );

  modport slave (
    output enable, frame_sync, fifo_empty, fifo_dout, row_ready,
    input  fifo_rd_en, byte_we, byte_idx, byte_data, row_valid, row_idx,
           frame_done, sync_err
  );
endinterface

// File: rtl/led_row_sched.sv
// Backlight-zone row scheduler: pulls ZONES_PER_ROW bytes per row from the zone
// FIFO into the packer, presents each row to the transmitter, tracks row index.
module led_row_sched #(
  parameter int unsigned ZONES_PER_ROW = 40,
  parameter int unsigned ROWS          = 34
) (
  input  logic            rd_clk,
  input  logic            rst_n,
  led_row_sched_if.master bus
);

  localparam int unsigned   CW        = 6;
  localparam logic [CW-1:0] ZONES     = CW'(ZONES_PER_ROW);
  localparam logic [CW-1:0] LAST_ZONE = CW'(ZONES_PER_ROW - 1);
  localparam logic [CW-1:0] LAST_ROW  = CW'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FILL    = 2'd1,
    ST_PRESENT = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] issued_q, issued_d;
  logic [CW-1:0] recvd_q, recvd_d;
  logic          byte_we_q, byte_we_d;
  logic [CW-1:0] byte_idx_q, byte_idx_d;
  logic          row_valid_q, row_valid_d;
  logic [CW-1:0] row_idx_q, row_idx_d;
  logic          frame_done_q, frame_done_d;
  logic          sync_err_q, sync_err_d;
  logic          rd_en_c;

  // State and output registers
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      issued_q     <= '0;
      recvd_q      <= '0;
      byte_we_q    <= 1'b0;
      byte_idx_q   <= '0;
      row_valid_q  <= 1'b0;
      row_idx_q    <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      issued_q     <= issued_d;
      recvd_q      <= recvd_d;
      byte_we_q    <= byte_we_d;
      byte_idx_q   <= byte_idx_d;
      row_valid_q  <= row_valid_d;
      row_idx_q    <= row_idx_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  // Next-state and output decode; frame_sync overrides everything at the end
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    recvd_d      = recvd_q;
    byte_we_d    = 1'b0;
    byte_idx_d   = byte_idx_q;
    row_idx_d    = row_idx_q;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    rd_en_c      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.enable) state_d = ST_FILL;
      end
      ST_FILL: begin
        rd_en_c = !bus.fifo_empty && (issued_q != ZONES);
        if (rd_en_c) begin
          issued_d   = issued_q + CW'(1);
          byte_we_d  = 1'b1;
          // slot index accounts for a byte landing in this same cycle
          byte_idx_d = recvd_q + CW'(byte_we_q);
        end
        if (byte_we_q) begin
          recvd_d = recvd_q + CW'(1);
          if (recvd_q == LAST_ZONE) state_d = ST_PRESENT;
        end
      end
      ST_PRESENT: begin
        if (bus.row_ready) begin
          issued_d = '0;
          recvd_d  = '0;
          if (row_idx_q == LAST_ROW) begin
            row_idx_d    = '0;
            frame_done_d = 1'b1;
          end else begin
            row_idx_d = row_idx_q + CW'(1);
          end
          state_d = bus.enable ? ST_FILL : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (bus.frame_sync) begin
      state_d      = ST_IDLE;
      issued_d     = '0;
      recvd_d      = '0;
      row_idx_d    = '0;
      rd_en_c      = 1'b0;
      byte_we_d    = 1'b0;
      byte_idx_d   = '0;
      frame_done_d = 1'b0;
      sync_err_d   = (row_idx_q != '0) || (issued_q != '0);
    end

    row_valid_d = (state_d == ST_PRESENT);
  end

  assign bus.fifo_rd_en = rd_en_c;
  assign bus.byte_we    = byte_we_q;
  assign bus.byte_idx   = byte_idx_q;
  assign bus.byte_data  = bus.fifo_dout;
  assign bus.row_valid  = row_valid_q;
  assign bus.row_idx    = row_idx_q;
  assign bus.frame_done = frame_done_q;
  assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_led_row_sched.sv
// Self-checking bench for led_row_sched: incrementing-data FIFO model, event
// monitor, and per-scenario tasks checked against a row/byte-level model.
module tb_led_row_sched;
  localparam int unsigned Z      = 40;
  localparam int unsigned R      = 34;
  localparam int          PERIOD = Z + 2;

  logic rd_clk = 1'b0;
  logic rst_n  = 1'b1;
  logic starve = 1'b0;

  led_row_sched_if bus ();

  led_row_sched #(.ZONES_PER_ROW(Z), .ROWS(R)) dut (
    .rd_clk (rd_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 rd_clk = ~rd_clk;

  assign bus.fifo_empty = starve;

  int n_tests = 0;
  int n_fail  = 0;
  int m_row   = 0;

  // Event monitor, sampled mid-cycle
  int         cyc = 0, rd_empty_cnt = 0, fd_cnt = 0, se_cnt = 0;
  logic       rd_seen = 1'b0;
  logic [7:0] gen = 8'h00;
  int we_idx_q[$];
  int we_data_q[$];
  int hs_row_q[$];
  int hs_cyc_q[$];
  int fd_cyc_q[$];

  always @(negedge rd_clk) begin
    rd_seen <= bus.fifo_rd_en;
    if (bus.fifo_rd_en && bus.fifo_empty) rd_empty_cnt <= rd_empty_cnt + 1;
    if (bus.byte_we) begin
      we_idx_q.push_back(int'(bus.byte_idx));
      we_data_q.push_back(int'(bus.byte_data));
    end
    if (bus.row_valid && bus.row_ready && !bus.frame_sync) begin
      hs_row_q.push_back(int'(bus.row_idx));
      hs_cyc_q.push_back(cyc);
    end
    if (bus.frame_done) begin
      fd_cnt <= fd_cnt + 1;
      fd_cyc_q.push_back(cyc);
    end
    if (bus.sync_err) se_cnt <= se_cnt + 1;
    cyc <= cyc + 1;
  end

  // Zone FIFO model: endless incrementing bytes, data one cycle after rd_en
  always @(posedge rd_clk) begin
    if (rd_seen) begin
      bus.fifo_dout <= gen;
      gen           <= gen + 8'd1;
    end
  end

  function automatic int next_row(input int r);
    return (r == int'(R) - 1) ? 0 : r + 1;
  endfunction

  task automatic tick();
    @(posedge rd_clk);
    #2;
  endtask

  task automatic test_reset();
    bus.enable = 1'b0; bus.frame_sync = 1'b0; bus.row_ready = 1'b0; starve = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    n_tests++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset fifo_rd_en got %b want 0", bus.fifo_rd_en); end
    n_tests++; if (bus.byte_we !== 1'b0) begin n_fail++; $display("FAIL reset byte_we got %b want 0", bus.byte_we); end
    n_tests++; if (bus.byte_idx !== 6'd0) begin n_fail++; $display("FAIL reset byte_idx got %0d want 0", bus.byte_idx); end
    n_tests++; if (bus.row_valid !== 1'b0) begin n_fail++; $display("FAIL reset row_valid got %b want 0", bus.row_valid); end
    n_tests++; if (bus.row_idx !== 6'd0) begin n_fail++; $display("FAIL reset row_idx got %0d want 0", bus.row_idx); end
    n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL reset frame_done got %b want 0", bus.frame_done); end
    n_tests++; if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL reset sync_err got %b want 0", bus.sync_err); end
    rst_n = 1'b1;
    repeat (2) tick();
    n_tests++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL idle_no_read got %b want 0", bus.fifo_rd_en); end
    m_row = 0;
  endtask

  task automatic test_nominal();
    int w0, h0, f0, s0, n, nb, budget, lastfd;
    logic [7:0] base;
    w0 = we_idx_q.size(); h0 = hs_row_q.size(); f0 = fd_cnt; s0 = se_cnt; base = gen;
    starve = 1'b0; bus.row_ready = 1'b1; bus.enable = 1'b1;
    budget = 0;
    while ((hs_row_q.size() - h0) < int'(R) && budget < int'(R) * PERIOD + 100) begin
      tick(); budget++;
      if ((hs_row_q.size() - h0) >= int'(R) - 1) bus.enable = 1'b0;
    end
    repeat (3) tick();
    n = hs_row_q.size() - h0;
    n_tests++; if (n != int'(R)) begin n_fail++; $display("FAIL nominal row_count got %0d want %0d", n, R); end
    for (int k = 0; k < n; k++) begin
      n_tests++; if (hs_row_q[h0+k] !== m_row) begin n_fail++; $display("FAIL nominal row_idx got %0d want %0d", hs_row_q[h0+k], m_row); end
      m_row = next_row(m_row);
    end
    for (int k = 1; k < n; k++) begin
      n_tests++; if (hs_cyc_q[h0+k] - hs_cyc_q[h0+k-1] != PERIOD) begin n_fail++; $display("FAIL nominal row_period got %0d want %0d", hs_cyc_q[h0+k] - hs_cyc_q[h0+k-1], PERIOD); end
    end
    nb = we_idx_q.size() - w0;
    n_tests++; if (nb != int'(Z * R)) begin n_fail++; $display("FAIL nominal byte_count got %0d want %0d", nb, Z * R); end
    for (int i = 0; i < nb; i++) begin
      n_tests++; if (we_idx_q[w0+i] !== i % int'(Z)) begin n_fail++; $display("FAIL nominal byte_idx got %0d want %0d", we_idx_q[w0+i], i % int'(Z)); end
      n_tests++; if (we_data_q[w0+i] !== (int'(base) + i) % 256) begin n_fail++; $display("FAIL nominal byte_data got %0d want %0d", we_data_q[w0+i], (int'(base) + i) % 256); end
    end
    n_tests++; if (fd_cnt - f0 != 1) begin n_fail++; $display("FAIL nominal frame_done_count got %0d want 1", fd_cnt - f0); end
    lastfd = (fd_cyc_q.size() > 0) ? fd_cyc_q[fd_cyc_q.size()-1] : -1;
    n_tests++; if (n < 1 || lastfd != hs_cyc_q[hs_cyc_q.size()-1] + 1) begin n_fail++; $display("FAIL nominal frame_done_time got %0d want last_handshake+1", lastfd); end
    n_tests++; if (se_cnt != s0) begin n_fail++; $display("FAIL nominal sync_err got %0d want 0", se_cnt - s0); end
    n_tests++; if (bus.row_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL nominal idle got valid=%b rd=%b want 0 0", bus.row_valid, bus.fifo_rd_en); end
    n_tests++; if (bus.row_idx !== 6'd0) begin n_fail++; $display("FAIL nominal wrap row_idx got %0d want 0", bus.row_idx); end
  endtask

  task automatic test_starvation();
    int w0, h0, e0, n, nb, budget;
    logic [7:0] base;
    w0 = we_idx_q.size(); h0 = hs_row_q.size(); e0 = rd_empty_cnt; base = gen;
    bus.row_ready = 1'b1; bus.enable = 1'b1;
    budget = 0;
    while ((hs_row_q.size() - h0) < 2 && budget < 8 * PERIOD + 100) begin
      starve = 1'($urandom_range(0, 1));
      tick(); budget++;
      if ((hs_row_q.size() - h0) >= 1) bus.enable = 1'b0;
    end
    starve = 1'b0;
    repeat (3) tick();
    n = hs_row_q.size() - h0;
    n_tests++; if (n != 2) begin n_fail++; $display("FAIL starve row_count got %0d want 2", n); end
    for (int k = 0; k < n; k++) begin
      n_tests++; if (hs_row_q[h0+k] !== m_row) begin n_fail++; $display("FAIL starve row_idx got %0d want %0d", hs_row_q[h0+k], m_row); end
      m_row = next_row(m_row);
    end
    n_tests++; if (rd_empty_cnt != e0) begin n_fail++; $display("FAIL starve rd_while_empty got %0d want 0", rd_empty_cnt - e0); end
    nb = we_idx_q.size() - w0;
    n_tests++; if (nb != 2 * int'(Z)) begin n_fail++; $display("FAIL starve byte_count got %0d want %0d", nb, 2 * Z); end
    for (int i = 0; i < nb; i++) begin
      n_tests++; if (we_idx_q[w0+i] !== i % int'(Z)) begin n_fail++; $display("FAIL starve byte_idx got %0d want %0d", we_idx_q[w0+i], i % int'(Z)); end
      n_tests++; if (we_data_q[w0+i] !== (int'(base) + i) % 256) begin n_fail++; $display("FAIL starve byte_data got %0d want %0d", we_data_q[w0+i], (int'(base) + i) % 256); end
    end
  endtask

  task automatic test_backpressure_enable();
    int h0, w1, budget;
    bus.enable = 1'b1; bus.row_ready = 1'b0; starve = 1'b0;
    budget = 0;
    while (bus.row_valid !== 1'b1 && budget < 3 * PERIOD) begin tick(); budget++; end
    n_tests++; if (bus.row_valid !== 1'b1) begin n_fail++; $display("FAIL bp row_valid_timeout got %b want 1", bus.row_valid); end
    h0 = hs_row_q.size();
    for (int c = 0; c < 10; c++) begin
      n_tests++; if (bus.row_valid !== 1'b1 || int'(bus.row_idx) !== m_row) begin n_fail++; $display("FAIL bp hold got valid=%b row=%0d want 1 %0d", bus.row_valid, bus.row_idx, m_row); end
      n_tests++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp rd_en got %b want 0", bus.fifo_rd_en); end
      tick();
    end
    bus.row_ready = 1'b1;
    tick();
    m_row = next_row(m_row);
    n_tests++; if (bus.row_valid !== 1'b0 || bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL bp resume got valid=%b rd=%b want 0 1", bus.row_valid, bus.fifo_rd_en); end
    n_tests++; if (int'(bus.row_idx) !== m_row) begin n_fail++; $display("FAIL bp next_row got %0d want %0d", bus.row_idx, m_row); end
    w1 = we_idx_q.size();
    budget = 0;
    while ((we_idx_q.size() - w1) < 20 && budget < PERIOD) begin tick(); budget++; end
    bus.enable = 1'b0;
    budget = 0;
    while ((hs_row_q.size() - h0) < 2 && budget < 2 * PERIOD) begin tick(); budget++; end
    n_tests++; if (hs_row_q.size() - h0 != 2 || hs_row_q[hs_row_q.size()-1] !== m_row) begin n_fail++; $display("FAIL en_off presented got count=%0d want 2 row %0d", hs_row_q.size() - h0, m_row); end
    m_row = next_row(m_row);
    repeat (4) tick();
    n_tests++; if (bus.row_valid !== 1'b0 || bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL en_off idle got valid=%b rd=%b want 0 0", bus.row_valid, bus.fifo_rd_en); end
    n_tests++; if (we_idx_q.size() - w1 != int'(Z)) begin n_fail++; $display("FAIL en_off byte_count got %0d want %0d", we_idx_q.size() - w1, Z); end
  endtask

  task automatic test_mid_sync();
    int h0, n, budget;
    bus.frame_sync = 1'b1;
    tick();
    bus.frame_sync = 1'b0;
    n_tests++; if (bus.sync_err !== (m_row != 0)) begin n_fail++; $display("FAIL realign sync_err got %b want %b", bus.sync_err, m_row != 0); end
    m_row = 0;
    bus.frame_sync = 1'b1;
    tick();
    bus.frame_sync = 1'b0;
    n_tests++; if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL start_sync sync_err got %b want 0", bus.sync_err); end
    h0 = hs_row_q.size();
    bus.enable = 1'b1; bus.row_ready = 1'b1;
    budget = 0;
    while ((hs_row_q.size() - h0) < 5 && budget < 6 * PERIOD) begin tick(); budget++; end
    n = hs_row_q.size() - h0;
    n_tests++; if (n != 5) begin n_fail++; $display("FAIL msync row_count got %0d want 5", n); end
    for (int k = 0; k < n; k++) begin
      n_tests++; if (hs_row_q[h0+k] !== m_row) begin n_fail++; $display("FAIL msync row_idx got %0d want %0d", hs_row_q[h0+k], m_row); end
      m_row = next_row(m_row);
    end
    budget = 0;
    while (!(bus.byte_we === 1'b1 && bus.byte_idx === 6'd17) && budget < 2 * PERIOD) begin tick(); budget++; end
    n_tests++; if (int'(bus.row_idx) !== m_row || bus.fifo_rd_en !== 1'b1) begin n_fail++; $display("FAIL msync setup got row=%0d rd=%b want %0d 1", bus.row_idx, bus.fifo_rd_en, m_row); end
    bus.frame_sync = 1'b1;
    #1;
    n_tests++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL msync rd_blocked got %b want 0", bus.fifo_rd_en); end
    tick();
    bus.frame_sync = 1'b0;
    m_row = 0;
    n_tests++; if (bus.byte_we !== 1'b0) begin n_fail++; $display("FAIL msync inflight_we got %b want 0", bus.byte_we); end
    n_tests++; if (bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL msync sync_err got %b want 1", bus.sync_err); end
    n_tests++; if (bus.row_idx !== 6'd0 || bus.row_valid !== 1'b0) begin n_fail++; $display("FAIL msync row got idx=%0d valid=%b want 0 0", bus.row_idx, bus.row_valid); end
    tick();
    n_tests++; if (bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL msync sync_err_pulse got %b want 0", bus.sync_err); end
    budget = 0;
    while (bus.byte_we !== 1'b1 && budget < 10) begin tick(); budget++; end
    n_tests++; if (bus.byte_we !== 1'b1 || bus.byte_idx !== 6'd0) begin n_fail++; $display("FAIL msync restart got we=%b idx=%0d want 1 0", bus.byte_we, bus.byte_idx); end
    bus.enable = 1'b0;
    h0 = hs_row_q.size();
    budget = 0;
    while ((hs_row_q.size() - h0) < 1 && budget < 2 * PERIOD) begin tick(); budget++; end
    n_tests++; if (hs_row_q.size() - h0 != 1 || hs_row_q[hs_row_q.size()-1] !== m_row) begin n_fail++; $display("FAIL msync next_row got count=%0d want 1 row %0d", hs_row_q.size() - h0, m_row); end
    m_row = next_row(m_row);
    repeat (3) tick();
  endtask

  task automatic test_collision();
    int hcnt, f0, s0, budget;
    hcnt = hs_row_q.size(); bus.enable = 1'b1; bus.row_ready = 1'b1;
    budget = 0;
    while (m_row != int'(R) - 1 && budget < int'(R) * PERIOD + 100) begin
      tick(); budget++;
      while (hcnt < hs_row_q.size()) begin
        n_tests++; if (hs_row_q[hcnt] !== m_row) begin n_fail++; $display("FAIL coll row_idx got %0d want %0d", hs_row_q[hcnt], m_row); end
        m_row = next_row(m_row); hcnt++;
      end
    end
    bus.row_ready = 1'b0;
    budget = 0;
    while (bus.row_valid !== 1'b1 && budget < 2 * PERIOD) begin tick(); budget++; end
    n_tests++; if (bus.row_valid !== 1'b1 || int'(bus.row_idx) !== int'(R) - 1) begin n_fail++; $display("FAIL coll setup got valid=%b row=%0d want 1 %0d", bus.row_valid, bus.row_idx, R - 1); end
    f0 = fd_cnt; s0 = se_cnt; hcnt = hs_row_q.size();
    bus.frame_sync = 1'b1; bus.row_ready = 1'b1; bus.enable = 1'b0;
    tick();
    bus.frame_sync = 1'b0;
    m_row = 0;
    n_tests++; if (bus.frame_done !== 1'b0) begin n_fail++; $display("FAIL coll frame_done got %b want 0", bus.frame_done); end
    n_tests++; if (bus.sync_err !== 1'b1) begin n_fail++; $display("FAIL coll sync_err got %b want 1", bus.sync_err); end
    n_tests++; if (bus.row_idx !== 6'd0 || bus.row_valid !== 1'b0) begin n_fail++; $display("FAIL coll row got idx=%0d valid=%b want 0 0", bus.row_idx, bus.row_valid); end
    repeat (3) tick();
    n_tests++; if (fd_cnt != f0 || se_cnt - s0 != 1) begin n_fail++; $display("FAIL coll pulses got fd=%0d se=%0d want 0 1", fd_cnt - f0, se_cnt - s0); end
    n_tests++; if (hs_row_q.size() != hcnt) begin n_fail++; $display("FAIL coll handshake got %0d want 0", hs_row_q.size() - hcnt); end
  endtask

  task automatic test_reset_mid_fill();
    int w0, h0, budget;
    bus.enable = 1'b1; bus.row_ready = 1'b1;
    budget = 0;
    while (!(bus.byte_we === 1'b1 && bus.byte_idx >= 6'd5) && budget < 2 * PERIOD) begin tick(); budget++; end
    rst_n = 1'b0;
    #1;
    n_tests++; if (bus.fifo_rd_en !== 1'b0 || bus.byte_we !== 1'b0 || bus.byte_idx !== 6'd0) begin n_fail++; $display("FAIL arst byte_path got rd=%b we=%b idx=%0d want 0 0 0", bus.fifo_rd_en, bus.byte_we, bus.byte_idx); end
    n_tests++; if (bus.row_valid !== 1'b0 || bus.row_idx !== 6'd0) begin n_fail++; $display("FAIL arst row got valid=%b idx=%0d want 0 0", bus.row_valid, bus.row_idx); end
    n_tests++; if (bus.frame_done !== 1'b0 || bus.sync_err !== 1'b0) begin n_fail++; $display("FAIL arst pulses got fd=%b se=%b want 0 0", bus.frame_done, bus.sync_err); end
    tick();
    rst_n = 1'b1;
    m_row = 0;
    w0 = we_idx_q.size(); h0 = hs_row_q.size();
    tick();
    bus.enable = 1'b0;
    budget = 0;
    while ((hs_row_q.size() - h0) < 1 && budget < 2 * PERIOD) begin tick(); budget++; end
    n_tests++; if (hs_row_q.size() - h0 != 1 || hs_row_q[hs_row_q.size()-1] !== m_row) begin n_fail++; $display("FAIL arst restart_row got count=%0d want 1 row %0d", hs_row_q.size() - h0, m_row); end
    n_tests++; if (we_idx_q.size() - w0 != int'(Z) || we_idx_q[w0] !== 0) begin n_fail++; $display("FAIL arst restart_bytes got count=%0d want %0d from idx 0", we_idx_q.size() - w0, Z); end
    m_row = next_row(m_row);
    repeat (3) tick();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_starvation();
    test_backpressure_enable();
    test_mid_sync();
    test_collision();
    test_reset_mid_fill();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout want finish");
    $fatal(1);
  end

endmodule
